// File: rtl/vga_scanout.sv
// Parametrised VGA scan-out engine: H/V timing, integer-upscaled framebuffer reads,
// and DAC-side outputs delayed to line up with the framebuffer read latency.
module vga_scanout #(
    parameter int PIXEL_W      = 12,
    parameter int ADDR_W       = 17,
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int SCALE        = 2,
    parameter int READ_LATENCY = 1,
    parameter bit HSYNC_POL    = 1'b0,
    parameter bit VSYNC_POL    = 1'b0
) (
    input  logic               clock,
    input  logic               nreset,
    input  logic [PIXEL_W-1:0] pixel_data,
    output logic [ADDR_W-1:0]  pixel_addr,
    output logic [PIXEL_W-1:0] pixel,
    output logic               h_sync,
    output logic               v_sync,
    output logic               de,
    output logic               v_blank,
    output logic               v_blank_interupt,
    output logic               frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_COLS  = H_ACTIVE / SCALE;
    localparam int V_ROWS  = V_ACTIVE / SCALE;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [HW-1:0]     H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]     H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0]     H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0]     HS_START   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]     HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0]     V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]     V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0]     V_ACT_LAST = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0]     VS_START   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]     VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SW-1:0]     S_LAST     = SW'(SCALE - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(H_COLS);

    if (SCALE < 1) begin : g_bad_scale
        $error("vga_scanout: SCALE must be >= 1");
    end
    if (READ_LATENCY < 1) begin : g_bad_latency
        $error("vga_scanout: READ_LATENCY must be >= 1");
    end
    if ((H_ACTIVE % SCALE) != 0 || (V_ACTIVE % SCALE) != 0) begin : g_bad_divide
        $error("vga_scanout: H_ACTIVE and V_ACTIVE must be divisible by SCALE");
    end
    if (longint'(H_COLS) * longint'(V_ROWS) > (longint'(1) << ADDR_W)) begin : g_bad_addr
        $error("vga_scanout: framebuffer does not fit in ADDR_W address bits");
    end

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic vb;
        logic fs;
        logic irq;
    } stage_t;

    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic [SW-1:0]     hsub_q, hsub_d;
    logic [SW-1:0]     vsub_q, vsub_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] row_q, row_d;

    stage_t                    raw_p0;
    stage_t [READ_LATENCY-1:0] dly_q;
    stage_t                    tail;

    always_comb begin
        h_d    = h_q + HW'(1);
        v_d    = v_q;
        hsub_d = hsub_q + SW'(1);
        col_d  = col_q;
        vsub_d = vsub_q;
        row_d  = row_q;

        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
        end

        // One framebuffer column per SCALE clocks; parked at 0 from the last active pixel on.
        if (h_q >= H_ACT_LAST) begin
            hsub_d = '0;
            col_d  = '0;
        end else if (hsub_q == S_LAST) begin
            hsub_d = '0;
            col_d  = col_q + ADDR_W'(1);
        end

        // Row base moves at the end of the active span so the blanking interval already
        // presents the next line's base; the last active line rewinds to 0 for the next frame.
        if (h_q == H_ACT_LAST && v_q < V_ACT) begin
            if (vsub_q == S_LAST) begin
                vsub_d = '0;
                row_d  = (v_q == V_ACT_LAST) ? '0 : row_q + ROW_STEP;
            end else begin
                vsub_d = vsub_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            h_q    <= '0;
            v_q    <= '0;
            hsub_q <= '0;
            vsub_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            hsub_q <= hsub_d;
            vsub_q <= vsub_d;
            col_q  <= col_d;
            row_q  <= row_d;
        end
    end

    // Stage 0: raw decode of the counter position
    always_comb begin
        raw_p0.active = (h_q < H_ACT) && (v_q < V_ACT);
        raw_p0.hs     = (h_q >= HS_START) && (h_q < HS_END);
        raw_p0.vs     = (v_q >= VS_START) && (v_q < VS_END);
        raw_p0.vb     = (v_q >= V_ACT);
        raw_p0.fs     = (h_q == '0) && (v_q == '0);
        raw_p0.irq    = (h_q == '0) && (v_q == V_ACT);
    end

    assign pixel_addr = row_q + (raw_p0.active ? col_q : '0);

    // Stages 1..READ_LATENCY: control delay matching the framebuffer read
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            dly_q <= '0;
        end else begin
            dly_q[0] <= raw_p0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign tail = dly_q[READ_LATENCY-1];

    // Output stage: every DAC-side signal registered from the same delayed control word
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            pixel            <= '0;
            de               <= 1'b0;
            h_sync           <= ~HSYNC_POL;
            v_sync           <= ~VSYNC_POL;
            v_blank          <= 1'b0;
            v_blank_interupt <= 1'b0;
            frame_start      <= 1'b0;
        end else begin
            pixel            <= tail.active ? pixel_data : '0;
            de               <= tail.active;
            h_sync           <= tail.hs ? HSYNC_POL : ~HSYNC_POL;
            v_sync           <= tail.vs ? VSYNC_POL : ~VSYNC_POL;
            v_blank          <= tail.vb;
            v_blank_interupt <= tail.irq;
            frame_start      <= tail.fs;
        end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout: three configurations (tiny, mid-size with
// inverted sync polarity and latency 3, default geometry) against a behavioural model.
`timescale 1ns/1ps
module tb_vga_scanout;
    typedef struct packed {
        int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, sc, lat;
        bit hpol, vpol;
    } cfg_t;

    typedef struct packed {
        logic [11:0] pix;
        logic de, hs, vs, vb, irq, fs;
    } exp_t;

    localparam cfg_t CA = '{ha:8, hfp:2, hsw:2, hbp:2, va:4, vfp:1, vsw:1, vbp:1,
                            sc:2, lat:2, hpol:1'b0, vpol:1'b0};
    localparam cfg_t CB = '{ha:32, hfp:4, hsw:8, hbp:4, va:24, vfp:2, vsw:2, vbp:2,
                            sc:2, lat:4, hpol:1'b1, vpol:1'b1};
    localparam cfg_t CC = '{ha:640, hfp:16, hsw:96, hbp:48, va:480, vfp:10, vsw:2, vbp:33,
                            sc:2, lat:4, hpol:1'b0, vpol:1'b0};

    int n_checks = 0;
    int n_fail   = 0;

    logic clock  = 1'b0;
    logic nreset = 1'b1;
    always #5 clock = ~clock;

    logic [16:0] pa_a, pa_c;
    logic [7:0]  pa_b;
    logic [11:0] pd_a, pd_b, pd_c, px_a, px_b, px_c;
    logic hs_a, vs_a, de_a, vb_a, irq_a, fs_a;
    logic hs_b, vs_b, de_b, vb_b, irq_b, fs_b;
    logic hs_c, vs_c, de_c, vb_c, irq_c, fs_c;
    exp_t obs_a, obs_b, obs_c;

    assign obs_a = {px_a, de_a, hs_a, vs_a, vb_a, irq_a, fs_a};
    assign obs_b = {px_b, de_b, hs_b, vs_b, vb_b, irq_b, fs_b};
    assign obs_c = {px_c, de_c, hs_c, vs_c, vb_c, irq_c, fs_c};

    vga_scanout #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                  .V_SYNC(1), .V_BP(1), .SCALE(2), .READ_LATENCY(1)) u_a (
        .clock(clock), .nreset(nreset), .pixel_data(pd_a), .pixel_addr(pa_a), .pixel(px_a),
        .h_sync(hs_a), .v_sync(vs_a), .de(de_a), .v_blank(vb_a),
        .v_blank_interupt(irq_a), .frame_start(fs_a));

    vga_scanout #(.ADDR_W(8), .H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4), .V_ACTIVE(24),
                  .V_FP(2), .V_SYNC(2), .V_BP(2), .SCALE(2), .READ_LATENCY(3),
                  .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)) u_b (
        .clock(clock), .nreset(nreset), .pixel_data(pd_b), .pixel_addr(pa_b), .pixel(px_b),
        .h_sync(hs_b), .v_sync(vs_b), .de(de_b), .v_blank(vb_b),
        .v_blank_interupt(irq_b), .frame_start(fs_b));

    vga_scanout #(.READ_LATENCY(3)) u_c (
        .clock(clock), .nreset(nreset), .pixel_data(pd_c), .pixel_addr(pa_c), .pixel(px_c),
        .h_sync(hs_c), .v_sync(vs_c), .de(de_c), .v_blank(vb_c),
        .v_blank_interupt(irq_c), .frame_start(fs_c));

    // Framebuffer models: data = address + 0x100, returned after the configured latency
    logic [11:0] fb_b [3];
    logic [11:0] fb_c [3];
    always_ff @(posedge clock) begin
        pd_a    <= 12'(pa_a) + 12'h100;
        fb_b[0] <= 12'(pa_b) + 12'h100;
        fb_b[1] <= fb_b[0];
        fb_b[2] <= fb_b[1];
        fb_c[0] <= 12'(pa_c) + 12'h100;
        fb_c[1] <= fb_c[0];
        fb_c[2] <= fb_c[1];
    end
    assign pd_b = fb_b[2];
    assign pd_c = fb_c[2];

    function automatic int model_addr(cfg_t c, int pos);
        int ht, vt, h, v;
        ht = c.ha + c.hfp + c.hsw + c.hbp;
        vt = c.va + c.vfp + c.vsw + c.vbp;
        h  = pos % ht;
        v  = (pos / ht) % vt;
        if (v >= c.va) return 0;
        if (h < c.ha) return (v / c.sc) * (c.ha / c.sc) + h / c.sc;
        if (v + 1 >= c.va) return 0;
        return ((v + 1) / c.sc) * (c.ha / c.sc);
    endfunction

    function automatic exp_t model_out(cfg_t c, int pos);
        exp_t e;
        int ht, vt, h, v;
        logic act;
        e.pix = 12'd0; e.de = 1'b0; e.hs = ~c.hpol; e.vs = ~c.vpol;
        e.vb = 1'b0; e.irq = 1'b0; e.fs = 1'b0;
        if (pos >= 0) begin
            ht  = c.ha + c.hfp + c.hsw + c.hbp;
            vt  = c.va + c.vfp + c.vsw + c.vbp;
            h   = pos % ht;
            v   = (pos / ht) % vt;
            act = (h < c.ha) && (v < c.va);
            e.de  = act;
            e.pix = act ? 12'(model_addr(c, pos) + 256) : 12'd0;
            if (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsw) e.hs = c.hpol;
            if (v >= c.va + c.vfp && v < c.va + c.vfp + c.vsw) e.vs = c.vpol;
            e.vb  = (v >= c.va);
            e.irq = (h == 0) && (v == c.va);
            e.fs  = (h == 0) && (v == 0);
        end
        return e;
    endfunction

    // Leaves the bench on a falling edge with reset just released (position 0).
    task automatic release_reset();
        nreset = 1'b0;
        repeat (2) @(negedge clock);
        nreset = 1'b1;
    endtask

    task automatic test_reset();
        nreset = 1'b1;
        #1;
        nreset = 1'b0;
        #1;
        n_checks++; if (obs_a !== model_out(CA, -1)) begin n_fail++; $display("FAIL reset_a: got %h expected %h", obs_a, model_out(CA, -1)); end
        n_checks++; if (obs_b !== model_out(CB, -1)) begin n_fail++; $display("FAIL reset_b: got %h expected %h", obs_b, model_out(CB, -1)); end
        n_checks++; if (obs_c !== model_out(CC, -1)) begin n_fail++; $display("FAIL reset_c: got %h expected %h", obs_c, model_out(CC, -1)); end
        n_checks++; if (pa_a !== 17'd0) begin n_fail++; $display("FAIL reset_addr_a: got %0d expected 0", pa_a); end
        n_checks++; if (pa_b !== 8'd0) begin n_fail++; $display("FAIL reset_addr_b: got %0d expected 0", pa_b); end
        n_checks++; if (pa_c !== 17'd0) begin n_fail++; $display("FAIL reset_addr_c: got %0d expected 0", pa_c); end
        repeat (3) @(negedge clock);
        n_checks++; if (obs_a !== model_out(CA, -1)) begin n_fail++; $display("FAIL reset_held_a: got %h expected %h", obs_a, model_out(CA, -1)); end
        n_checks++; if (pa_a !== 17'd0) begin n_fail++; $display("FAIL reset_held_addr: got %0d expected 0", pa_a); end
    endtask

    task automatic test_addr();
        logic [31:0] l01, l2;
        int h, v;
        l01 = 32'h33221100;
        l2  = 32'h77665544;
        release_reset();
        for (int k = 0; k < 2 * 98; k++) begin
            h = k % 14;
            v = (k / 14) % 7;
            n_checks++;
            if (pa_a !== 17'(model_addr(CA, k))) begin
                n_fail++; $display("FAIL addr_model k=%0d: got %0d expected %0d", k, pa_a, model_addr(CA, k));
            end
            if (v < 3 && h < 8) begin
                n_checks++;
                if (pa_a !== 17'((v == 2) ? l2[4*h +: 4] : l01[4*h +: 4])) begin
                    n_fail++; $display("FAIL addr_line k=%0d: got %0d expected %0d", k, pa_a, (v == 2) ? l2[4*h +: 4] : l01[4*h +: 4]);
                end
            end
            if (v >= 4) begin
                n_checks++;
                if (pa_a !== 17'd0) begin n_fail++; $display("FAIL addr_vblank k=%0d: got %0d expected 0", k, pa_a); end
            end
            @(negedge clock);
        end
    endtask

    task automatic test_pixel();
        exp_t q[$];
        exp_t e;
        release_reset();
        for (int i = 0; i < CA.lat; i++) q.push_back(model_out(CA, -1));
        for (int k = 0; k < 2 * 98; k++) begin
            q.push_back(model_out(CA, k));
            e = q.pop_front();
            n_checks++; if (px_a !== e.pix) begin n_fail++; $display("FAIL pixel k=%0d: got %h expected %h", k, px_a, e.pix); end
            n_checks++; if (de_a !== e.de) begin n_fail++; $display("FAIL de k=%0d: got %b expected %b", k, de_a, e.de); end
            if (de_a === 1'b0) begin
                n_checks++; if (px_a !== 12'd0) begin n_fail++; $display("FAIL pixel_blank k=%0d: got %h expected 0", k, px_a); end
            end
            if (k >= 2 && k < 10) begin
                n_checks++;
                if (px_a !== 12'(12'h100 + (k - 2) / 2)) begin
                    n_fail++; $display("FAIL pixel_first k=%0d: got %h expected %h", k, px_a, 12'(12'h100 + (k - 2) / 2));
                end
            end
            @(negedge clock);
        end
    endtask

    task automatic test_sync();
        logic [1:0] q[$];
        logic [1:0] e;
        logic prev_hs, prev_vs;
        int last_hf, last_vf, h, v;
        last_hf = -1; last_vf = -1;
        release_reset();
        prev_hs = hs_a; prev_vs = vs_a;
        for (int i = 0; i < CA.lat; i++) q.push_back(2'b11);
        for (int k = 0; k < 3 * 98; k++) begin
            h = k % 14;
            v = (k / 14) % 7;
            q.push_back({!(h == 10 || h == 11), !(v == 5)});
            e = q.pop_front();
            n_checks++; if (hs_a !== e[1]) begin n_fail++; $display("FAIL hsync k=%0d: got %b expected %b", k, hs_a, e[1]); end
            n_checks++; if (vs_a !== e[0]) begin n_fail++; $display("FAIL vsync k=%0d: got %b expected %b", k, vs_a, e[0]); end
            if (prev_hs === 1'b1 && hs_a === 1'b0) begin
                if (last_hf >= 0) begin
                    n_checks++; if (k - last_hf != 14) begin n_fail++; $display("FAIL hsync_period: got %0d expected 14", k - last_hf); end
                end
                last_hf = k;
            end
            if (prev_vs === 1'b1 && vs_a === 1'b0) begin
                if (last_vf >= 0) begin
                    n_checks++; if (k - last_vf != 98) begin n_fail++; $display("FAIL vsync_period: got %0d expected 98", k - last_vf); end
                end
                last_vf = k;
            end
            prev_hs = hs_a; prev_vs = vs_a;
            @(negedge clock);
        end
        n_checks++; if (last_vf < 0) begin n_fail++; $display("FAIL vsync_seen: got none expected a falling edge"); end
    endtask

    task automatic test_pulses();
        exp_t q[$];
        exp_t e;
        int n_irq, n_fs;
        n_irq = 0; n_fs = 0;
        release_reset();
        for (int i = 0; i < CA.lat; i++) q.push_back(model_out(CA, -1));
        for (int k = 0; k < 3 * 98; k++) begin
            q.push_back(model_out(CA, k));
            e = q.pop_front();
            n_checks++; if (irq_a !== e.irq) begin n_fail++; $display("FAIL vblank_irq k=%0d: got %b expected %b", k, irq_a, e.irq); end
            n_checks++; if (fs_a !== e.fs) begin n_fail++; $display("FAIL frame_start k=%0d: got %b expected %b", k, fs_a, e.fs); end
            n_checks++; if (vb_a !== e.vb) begin n_fail++; $display("FAIL v_blank k=%0d: got %b expected %b", k, vb_a, e.vb); end
            if (irq_a === 1'b1) n_irq++;
            if (fs_a === 1'b1) n_fs++;
            @(negedge clock);
        end
        n_checks++; if (n_irq != 3) begin n_fail++; $display("FAIL irq_count: got %0d expected 3", n_irq); end
        n_checks++; if (n_fs != 3) begin n_fail++; $display("FAIL fs_count: got %0d expected 3", n_fs); end
    endtask

    task automatic test_mid();
        exp_t q[$];
        exp_t e;
        int first_de, fs1, fs2, max_addr;
        first_de = -1; fs1 = -1; fs2 = -1; max_addr = 0;
        release_reset();
        for (int i = 0; i < CB.lat; i++) q.push_back(model_out(CB, -1));
        for (int k = 0; k < 1440 + 60; k++) begin
            q.push_back(model_out(CB, k));
            e = q.pop_front();
            n_checks++; if (obs_b !== e) begin n_fail++; $display("FAIL mid_outputs k=%0d: got %h expected %h", k, obs_b, e); end
            n_checks++; if (pa_b !== 8'(model_addr(CB, k))) begin n_fail++; $display("FAIL mid_addr k=%0d: got %0d expected %0d", k, pa_b, model_addr(CB, k)); end
            if (int'(pa_b) > max_addr) max_addr = int'(pa_b);
            if (de_b === 1'b1 && first_de < 0) begin
                first_de = k;
                n_checks++; if (px_b !== 12'h100) begin n_fail++; $display("FAIL mid_first_pixel: got %h expected 100", px_b); end
            end
            if (fs_b === 1'b1) begin
                if (fs1 < 0) fs1 = k;
                else if (fs2 < 0) fs2 = k;
            end
            @(negedge clock);
        end
        n_checks++; if (max_addr != 191) begin n_fail++; $display("FAIL mid_last_addr: got %0d expected 191", max_addr); end
        n_checks++; if (first_de != 4) begin n_fail++; $display("FAIL mid_de_offset: got %0d expected 4", first_de); end
        n_checks++; if (fs1 != 4 || fs2 - fs1 != 1440) begin n_fail++; $display("FAIL mid_frame_len: got %0d..%0d expected 4..1444", fs1, fs2); end
    endtask

    task automatic test_default();
        exp_t q[$];
        exp_t e;
        int first_de, last_hf;
        logic prev_hs;
        first_de = -1; last_hf = -1;
        release_reset();
        prev_hs = hs_c;
        for (int i = 0; i < CC.lat; i++) q.push_back(model_out(CC, -1));
        for (int k = 0; k < 2 * 800 + 20; k++) begin
            q.push_back(model_out(CC, k));
            e = q.pop_front();
            n_checks++; if (obs_c !== e) begin n_fail++; $display("FAIL dflt_outputs k=%0d: got %h expected %h", k, obs_c, e); end
            n_checks++; if (pa_c !== 17'(model_addr(CC, k))) begin n_fail++; $display("FAIL dflt_addr k=%0d: got %0d expected %0d", k, pa_c, model_addr(CC, k)); end
            if (de_c === 1'b1 && first_de < 0) first_de = k;
            if (prev_hs === 1'b1 && hs_c === 1'b0) begin
                if (last_hf >= 0) begin
                    n_checks++; if (k - last_hf != 800) begin n_fail++; $display("FAIL dflt_hperiod: got %0d expected 800", k - last_hf); end
                end
                last_hf = k;
            end
            prev_hs = hs_c;
            @(negedge clock);
        end
        n_checks++; if (first_de != 4) begin n_fail++; $display("FAIL dflt_de_offset: got %0d expected 4", first_de); end
    endtask

    task automatic test_midframe_reset();
        exp_t q[$];
        exp_t e;
        release_reset();
        repeat (2 * 14 + 5) @(negedge clock);
        nreset = 1'b0;
        #1;
        n_checks++; if (obs_a !== model_out(CA, -1)) begin n_fail++; $display("FAIL midrst_outputs: got %h expected %h", obs_a, model_out(CA, -1)); end
        n_checks++; if (pa_a !== 17'd0) begin n_fail++; $display("FAIL midrst_addr: got %0d expected 0", pa_a); end
        @(negedge clock);
        nreset = 1'b1;
        for (int i = 0; i < CA.lat; i++) q.push_back(model_out(CA, -1));
        for (int k = 0; k < 20; k++) begin
            q.push_back(model_out(CA, k));
            e = q.pop_front();
            n_checks++; if (obs_a !== e) begin n_fail++; $display("FAIL midrst_after k=%0d: got %h expected %h", k, obs_a, e); end
            n_checks++; if (pa_a !== 17'(model_addr(CA, k))) begin n_fail++; $display("FAIL midrst_addr_after k=%0d: got %0d expected %0d", k, pa_a, model_addr(CA, k)); end
            n_checks++; if (fs_a !== (k == 2)) begin n_fail++; $display("FAIL midrst_frame_start k=%0d: got %b expected %b", k, fs_a, (k == 2)); end
            @(negedge clock);
        end
    endtask

    initial begin
        test_reset();
        test_addr();
        test_pixel();
        test_sync();
        test_pulses();
        test_mid();
        test_default();
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
